lr_frame_loader: RTL and testbench
==================================

# lr_frame_loader

Upstream loader for the linear-regression training engine. Receives the training set as a byte stream from the host link (PC/Python side, through the UART receiver), parses one frame, and writes Q8.8 features, targets and initial weights into the engine's feature RAM, target and weight registers. When a frame passes its checksum, the loader pulses `load_done` and publishes the frame dimensions, and the engine may start iterating.

## Interface
- `MAX_DP`, 4, maximum data points; `dps` must be in 1..MAX_DP
- `MAX_FEAT`, 4, maximum features; `features` must be in 1..MAX_FEAT
- `HDR`, 8'hA5, frame start byte
- `CLK`  in  1  single clock, rising edge
- `RST`  in  1  asynchronous, active-high reset
- `in_data`  in  8  stream byte
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  loader accepts a byte; a transfer occurs on a rising edge where `in_valid & in_ready`
- `feat_we`  out  1  write strobe, feature RAM
- `y_we`  out  1  write strobe, target register `y[wr_dp]`
- `wt_we`  out  1  write strobe, weight register `wt[wr_feat]`
- `wr_dp`  out  2  data-point index
- `wr_feat`  out  2  feature index
- `wr_data`  out  16  signed Q8.8 word
- `num_dps`  out  3  dps of the last good frame
- `num_features`  out  3  features of the last good frame
- `load_done`  out  1  one-cycle pulse: frame good
- `load_err`  out  1  one-cycle pulse: frame rejected
- `busy`  out  1  high from header accept until done or err

## Operation
- Frame format, in byte order:
  - `HDR`.
  - `DIM` byte: `[7:4]`=dps, `[3:0]`=features.
  - For each dp = 0..dps-1: features × (hi, lo) feature words, then (hi, lo) y word.
  - features × (hi, lo) weight words.
  - `CSUM` byte = XOR of every byte from `DIM` through the last weight lo byte.
- Total length = 3 + 2·dps·(features+1) + 2·features. For a 4×4 frame this is 51 bytes.
- States: IDLE, DIM, FEAT_HI, FEAT_LO, Y_HI, Y_LO, W_HI, W_LO, CSUM, DONE, ERR.
- IDLE: bytes other than `HDR` are consumed and discarded. `HDR` moves to DIM and sets `busy`.
- DIM:
  - If dps or features is 0 or exceeds its maximum, go to ERR.
  - Otherwise latch them internally, clear the XOR accumulator to the DIM byte, clear the dp and feature counters, and go to FEAT_HI.
- Each HI byte is latched. The matching LO byte forms the word {hi, lo}.
- In the cycle after a LO-byte transfer, exactly one strobe (`feat_we`, `y_we` or `wt_we`) is high, and `wr_dp`, `wr_feat` and `wr_data` are valid with it.
- Feature counter wraps at features-1. After the last feature go to Y_HI. After Y_LO, dp increments. After the last dp go to W_HI. After the last weight go to CSUM.
- CSUM:
  - Match: go to DONE. Latch `num_dps`/`num_features` from the frame and pulse `load_done`.
  - Mismatch: go to ERR and pulse `load_err`. `num_*` keep their old values.
- DONE and ERR each last one cycle with `in_ready`=0, then return to IDLE.
- Words already written before an error stay written. The engine must not start without `load_done`.
- A `HDR` byte arriving mid-frame is treated as data; there is no resync.
- Data words are passed through unmodified. The sign is carried in the hi byte (two's complement Q8.8).

## Timing
- Reset values:
  - `in_ready`=0 while `RST` is high, and 1 in the first cycle after release.
  - Every strobe, `load_done`, `load_err` and `busy` = 0.
  - `wr_*` = 0.
  - `num_dps`=`MAX_DP`, `num_features`=`MAX_FEAT`.
  - State = IDLE; all counters and the XOR accumulator cleared.
- `RST` asserted mid-frame aborts immediately. No strobe, `load_done` or `load_err` is produced. The next frame must start with `HDR`.
- Strobe latency: 1 cycle after the LO-byte transfer.
- `load_done`/`load_err`: 1 cycle after the CSUM transfer. `load_err` for a bad DIM comes 1 cycle after the DIM transfer.
- `in_ready`=1 in every state except DONE, ERR and reset, so full rate is one byte per cycle.
- `in_valid` gaps of any length are allowed. The state holds while `in_valid`=0.
- Write strobes never coincide with `load_done`/`load_err`.

## Test plan
- Good 4×4 frame, back-to-back bytes. Features match the engine's default set (dp0 = 0200, 0400, 0300, 0600 …), y = 0F00, 1200, 0F00, 1000, weights 0040 ×4.
  - Required: 16 `feat_we` with correct `(wr_dp, wr_feat, wr_data)`, then 4 `y_we`, then 4 `wt_we`.
  - `load_done` one cycle after byte 51; `num_dps`=4, `num_features`=4.
- Same frame with the CSUM byte XOR 0x01 -> all 24 writes occur, `load_err` pulses, no `load_done`, `num_*` unchanged.
- Leading bytes 00, 5A, FF, then `DIM`=8'h50 -> garbage ignored, `load_err` one cycle after DIM, no strobes, next `HDR` accepted 2 cycles later.
- 2×3 frame with a feature word FE80 (-1.5) and `in_valid` toggling every other cycle -> 6 `feat_we` + 2 `y_we` + 3 `wt_we`, `wr_data`=FE80 at the right index, `load_done`, `num_dps`=2, `num_features`=3.
- `RST` pulsed after byte 20 of a 4×4 frame, then a full good frame -> no done or err from the aborted frame, outputs at reset values, and the second frame completes normally.

Source files
------------

// File: rtl/lr_frame_loader.sv
// lr_frame_loader: parses one training-set frame from the host byte stream
// and writes Q8.8 features, targets and initial weights into the engine.
// A frame is announced as good only after its XOR checksum matches.
module lr_frame_loader #(
  parameter int unsigned MAX_DP   = 4,
  parameter int unsigned MAX_FEAT = 4,
  parameter logic [7:0]  HDR      = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_in_data,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  output logic        o_feat_we,
  output logic        o_y_we,
  output logic        o_wt_we,
  output logic [1:0]  o_wr_dp,
  output logic [1:0]  o_wr_feat,
  output logic [15:0] o_wr_data,
  output logic [2:0]  o_num_dps,
  output logic [2:0]  o_num_features,
  output logic        o_load_done,
  output logic        o_load_err,
  output logic        o_busy
);

  localparam int unsigned DIM_W = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 3;
  localparam logic [DIM_W-1:0] MAX_DP_D   = DIM_W'(MAX_DP);
  localparam logic [DIM_W-1:0] MAX_FEAT_D = DIM_W'(MAX_FEAT);

  typedef enum logic [3:0] {
    S_IDLE, S_DIM, S_FEAT_HI, S_FEAT_LO, S_Y_HI, S_Y_LO,
    S_W_HI, S_W_LO, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t           r_state;
  logic [7:0]       r_hi;
  logic [7:0]       r_xor;
  logic [IDX_W-1:0] r_dp;
  logic [IDX_W-1:0] r_feat;
  logic [CNT_W-1:0] r_ndp;
  logic [CNT_W-1:0] r_nfeat;

  logic             w_xfer;
  logic [15:0]      w_word;
  logic [DIM_W-1:0] w_dim_dp;
  logic [DIM_W-1:0] w_dim_feat;
  logic             w_dim_ok;
  logic             w_last_feat;
  logic             w_last_dp;

  // Handshake is open everywhere except the one-cycle DONE/ERR states and reset
  assign o_in_ready  = ~i_rst & (r_state != S_DONE) & (r_state != S_ERR);
  assign w_xfer      = i_in_valid & o_in_ready;
  assign w_word      = {r_hi, i_in_data};
  assign w_dim_dp    = i_in_data[7:4];
  assign w_dim_feat  = i_in_data[3:0];
  assign w_dim_ok    = (w_dim_dp != '0) && (w_dim_dp <= MAX_DP_D) &&
                       (w_dim_feat != '0) && (w_dim_feat <= MAX_FEAT_D);
  assign w_last_feat = ({1'b0, r_feat} == (r_nfeat - CNT_W'(1)));
  assign w_last_dp   = ({1'b0, r_dp} == (r_ndp - CNT_W'(1)));

  // Frame parser FSM with registered write strobes and status pulses
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_hi           <= '0;
      r_xor          <= '0;
      r_dp           <= '0;
      r_feat         <= '0;
      r_ndp          <= '0;
      r_nfeat        <= '0;
      o_feat_we      <= 1'b0;
      o_y_we         <= 1'b0;
      o_wt_we        <= 1'b0;
      o_wr_dp        <= '0;
      o_wr_feat      <= '0;
      o_wr_data      <= '0;
      o_num_dps      <= CNT_W'(MAX_DP);
      o_num_features <= CNT_W'(MAX_FEAT);
      o_load_done    <= 1'b0;
      o_load_err     <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_feat_we   <= 1'b0;
      o_y_we      <= 1'b0;
      o_wt_we     <= 1'b0;
      o_load_done <= 1'b0;
      o_load_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer && (i_in_data == HDR)) begin
            r_state <= S_DIM;
            o_busy  <= 1'b1;
          end
        end
        S_DIM: begin
          if (w_xfer) begin
            if (w_dim_ok) begin
              r_ndp   <= CNT_W'(w_dim_dp);
              r_nfeat <= CNT_W'(w_dim_feat);
              r_xor   <= i_in_data;
              r_dp    <= '0;
              r_feat  <= '0;
              r_state <= S_FEAT_HI;
            end else begin
              o_load_err <= 1'b1;
              o_busy     <= 1'b0;
              r_state    <= S_ERR;
            end
          end
        end
        S_FEAT_HI, S_Y_HI, S_W_HI: begin
          if (w_xfer) begin
            r_hi  <= i_in_data;
            r_xor <= r_xor ^ i_in_data;
            case (r_state)
              S_FEAT_HI: r_state <= S_FEAT_LO;
              S_Y_HI:    r_state <= S_Y_LO;
              default:   r_state <= S_W_LO;
            endcase
          end
        end
        S_FEAT_LO: begin
          if (w_xfer) begin
            r_xor     <= r_xor ^ i_in_data;
            o_feat_we <= 1'b1;
            o_wr_dp   <= r_dp;
            o_wr_feat <= r_feat;
            o_wr_data <= w_word;
            if (w_last_feat) begin
              r_feat  <= '0;
              r_state <= S_Y_HI;
            end else begin
              r_feat  <= r_feat + IDX_W'(1);
              r_state <= S_FEAT_HI;
            end
          end
        end
        S_Y_LO: begin
          if (w_xfer) begin
            r_xor     <= r_xor ^ i_in_data;
            o_y_we    <= 1'b1;
            o_wr_dp   <= r_dp;
            o_wr_feat <= '0;
            o_wr_data <= w_word;
            if (w_last_dp) begin
              r_dp    <= '0;
              r_state <= S_W_HI;
            end else begin
              r_dp    <= r_dp + IDX_W'(1);
              r_state <= S_FEAT_HI;
            end
          end
        end
        S_W_LO: begin
          if (w_xfer) begin
            r_xor     <= r_xor ^ i_in_data;
            o_wt_we   <= 1'b1;
            o_wr_dp   <= '0;
            o_wr_feat <= r_feat;
            o_wr_data <= w_word;
            if (w_last_feat) begin
              r_feat  <= '0;
              r_state <= S_CSUM;
            end else begin
              r_feat  <= r_feat + IDX_W'(1);
              r_state <= S_W_HI;
            end
          end
        end
        S_CSUM: begin
          if (w_xfer) begin
            o_busy <= 1'b0;
            if (i_in_data == r_xor) begin
              o_load_done    <= 1'b1;
              o_num_dps      <= r_ndp;
              o_num_features <= r_nfeat;
              r_state        <= S_DONE;
            end else begin
              o_load_err <= 1'b1;
              r_state    <= S_ERR;
            end
          end
        end
        S_DONE, S_ERR: r_state <= S_IDLE;
        default:       r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lr_frame_loader.sv
// Bench for lr_frame_loader: frames built from the byte format, expected
// writes and outcomes derived from the frame contents.
module tb_lr_frame_loader;

  typedef struct packed {
    logic [1:0]  kind;   // 0 feature, 1 target, 2 weight
    logic [1:0]  dp;
    logic [1:0]  feat;
    logic [15:0] data;
  } wr_t;

  logic        i_clk, i_rst, i_in_valid;
  logic [7:0]  i_in_data;
  logic        o_in_ready, o_feat_we, o_y_we, o_wt_we;
  logic [1:0]  o_wr_dp, o_wr_feat;
  logic [15:0] o_wr_data;
  logic [2:0]  o_num_dps, o_num_features;
  logic        o_load_done, o_load_err, o_busy;

  lr_frame_loader dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_in_data(i_in_data), .i_in_valid(i_in_valid),
    .o_in_ready(o_in_ready), .o_feat_we(o_feat_we), .o_y_we(o_y_we), .o_wt_we(o_wt_we),
    .o_wr_dp(o_wr_dp), .o_wr_feat(o_wr_feat), .o_wr_data(o_wr_data),
    .o_num_dps(o_num_dps), .o_num_features(o_num_features),
    .o_load_done(o_load_done), .o_load_err(o_load_err), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int overlap_viol = 0;
  wr_t obs_q[$];
  wr_t exp_q[$];
  int done_q[$];
  int err_q[$];
  int xfer_q[$];
  logic [7:0]  frame_q[$];
  logic [7:0]  m_csum;
  logic [15:0] m_x[4][4];
  logic [15:0] m_y[4];
  logic [15:0] m_w[4];
  int m_num_dps = 4;
  int m_num_f = 4;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Observe strobes and status pulses mid-cycle
  always @(negedge i_clk) begin
    if (!i_rst) begin
      int n;
      n = int'(o_feat_we) + int'(o_y_we) + int'(o_wt_we);
      if (n > 1 || (n > 0 && (o_load_done || o_load_err)) || (o_load_done && o_load_err))
        overlap_viol++;
      if (o_feat_we) obs_q.push_back(wr_t'{2'd0, o_wr_dp, o_wr_feat, o_wr_data});
      if (o_y_we)    obs_q.push_back(wr_t'{2'd1, o_wr_dp, o_wr_feat, o_wr_data});
      if (o_wt_we)   obs_q.push_back(wr_t'{2'd2, o_wr_dp, o_wr_feat, o_wr_data});
      if (o_load_done) done_q.push_back(cyc);
      if (o_load_err)  err_q.push_back(cyc);
    end
  end

  task automatic clear_obs();
    obs_q.delete();
    done_q.delete();
    err_q.delete();
    overlap_viol = 0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit sum);
    frame_q.push_back(b);
    if (sum) m_csum = m_csum ^ b;
  endtask

  task automatic set_default();
    logic [15:0] d [4][4];
    d[0] = '{16'h0200, 16'h0400, 16'h0300, 16'h0600};
    d[1] = '{16'h0100, 16'h0300, 16'h0200, 16'h0500};
    d[2] = '{16'h0300, 16'h0500, 16'h0400, 16'h0700};
    d[3] = '{16'h0200, 16'h0200, 16'h0500, 16'h0400};
    m_x = d;
    m_y = '{16'h0F00, 16'h1200, 16'h0F00, 16'h1000};
    m_w = '{16'h0040, 16'h0040, 16'h0040, 16'h0040};
  endtask

  task automatic fill_random();
    for (int d = 0; d < 4; d++) begin
      for (int f = 0; f < 4; f++) m_x[d][f] = 16'($urandom);
      m_y[d] = 16'($urandom);
      m_w[d] = 16'($urandom);
    end
  endtask

  // Serialise a frame from the model arrays and list the writes it implies
  task automatic make_frame(input int ndp, input int nf, input bit bad);
    frame_q.delete();
    exp_q.delete();
    m_csum = 8'h00;
    push_byte(8'hA5, 1'b0);
    push_byte({4'(ndp), 4'(nf)}, 1'b1);
    for (int d = 0; d < ndp; d++) begin
      for (int f = 0; f < nf; f++) begin
        push_byte(m_x[d][f][15:8], 1'b1);
        push_byte(m_x[d][f][7:0], 1'b1);
        exp_q.push_back(wr_t'{2'd0, 2'(d), 2'(f), m_x[d][f]});
      end
      push_byte(m_y[d][15:8], 1'b1);
      push_byte(m_y[d][7:0], 1'b1);
      exp_q.push_back(wr_t'{2'd1, 2'(d), 2'd0, m_y[d]});
    end
    for (int f = 0; f < nf; f++) begin
      push_byte(m_w[f][15:8], 1'b1);
      push_byte(m_w[f][7:0], 1'b1);
      exp_q.push_back(wr_t'{2'd2, 2'd0, 2'(f), m_w[f]});
    end
    push_byte(m_csum ^ (bad ? 8'h01 : 8'h00), 1'b0);
  endtask

  // Number of observed writes that disagree with the expected list
  function automatic int count_bad();
    int bad;
    int n;
    bad = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size()
                                        : exp_q.size() - obs_q.size();
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data) bad++;
      else if (exp_q[i].kind == 2'd0 &&
               (obs_q[i].dp !== exp_q[i].dp || obs_q[i].feat !== exp_q[i].feat)) bad++;
      else if (exp_q[i].kind == 2'd1 && obs_q[i].dp !== exp_q[i].dp) bad++;
      else if (exp_q[i].kind == 2'd2 && obs_q[i].feat !== exp_q[i].feat) bad++;
    end
    return bad;
  endfunction

  // Drive frame_q; mode 0 back-to-back, 1 valid every other cycle, 2 random gaps
  task automatic send_bytes(input int mode, input int nmax);
    bit rdy;
    int guard;
    xfer_q.delete();
    for (int k = 0; k < frame_q.size() && k < nmax; k++) begin
      int gaps;
      gaps = (mode == 1 && k > 0) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gaps) begin
        i_in_valid = 1'b0;
        i_in_data  = 8'($urandom);
        @(posedge i_clk); #1;
      end
      i_in_valid = 1'b1;
      i_in_data  = frame_q[k];
      guard = 0;
      do begin
        @(negedge i_clk);
        rdy = o_in_ready;
        @(posedge i_clk); #1;
        guard++;
      end while (!rdy && guard < 20);
      if (!rdy) begin
        checks++; errors++;
        $display("FAIL send_timeout byte %0d in_ready=%b required 1", k, o_in_ready);
        i_in_valid = 1'b0;
        return;
      end
      xfer_q.push_back(cyc);
    end
    i_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_in_valid = 1'b0; i_in_data = 8'h00;
    idle(3);
    checks++;
    if (o_in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b required 0", o_in_ready); end
    checks++;
    if ({o_feat_we, o_y_we, o_wt_we, o_load_done, o_load_err, o_busy} !== 6'b0) begin
      errors++; $display("FAIL rst_flags got %b required 000000",
                         {o_feat_we, o_y_we, o_wt_we, o_load_done, o_load_err, o_busy});
    end
    checks++;
    if ({o_wr_dp, o_wr_feat, o_wr_data} !== 20'h0) begin
      errors++; $display("FAIL rst_wr got %h required 0", {o_wr_dp, o_wr_feat, o_wr_data});
    end
    checks++;
    if (o_num_dps !== 3'd4 || o_num_features !== 3'd4) begin
      errors++; $display("FAIL rst_num got %0d/%0d required 4/4", o_num_dps, o_num_features);
    end
    i_rst = 1'b0;
    #1;
    checks++;
    if (o_in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b required 1", o_in_ready); end
    idle(1);
  endtask

  task automatic test_good_4x4();
    int bad;
    set_default();
    make_frame(4, 4, 1'b0);
    clear_obs();
    send_bytes(0, 1000);
    checks++;
    if (o_load_done !== 1'b1 || o_in_ready !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL good_done_cycle done/ready/busy=%b%b%b required 100",
                         o_load_done, o_in_ready, o_busy);
    end
    idle(2);
    bad = count_bad();
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL good_writes bad=%0d obs=%0d required 0 of %0d", bad, obs_q.size(), exp_q.size()); end
    checks++;
    if (xfer_q.size() != 51 || xfer_q[xfer_q.size()-1] - xfer_q[0] != 50) begin
      errors++; $display("FAIL good_rate bytes=%0d span=%0d required 51/50", xfer_q.size(),
                         xfer_q.size() > 0 ? xfer_q[xfer_q.size()-1] - xfer_q[0] : -1);
    end
    checks++;
    if (done_q.size() != 1 || err_q.size() != 0 || done_q[0] != xfer_q[xfer_q.size()-1]) begin
      errors++; $display("FAIL good_done count=%0d err=%0d required 1/0 at cycle %0d",
                         done_q.size(), err_q.size(), xfer_q[xfer_q.size()-1]);
    end
    m_num_dps = 4; m_num_f = 4;
    checks++;
    if (int'(o_num_dps) != m_num_dps || int'(o_num_features) != m_num_f) begin
      errors++; $display("FAIL good_num got %0d/%0d required %0d/%0d", o_num_dps, o_num_features, m_num_dps, m_num_f);
    end
    checks++;
    if (overlap_viol !== 0) begin errors++; $display("FAIL good_overlap got %0d required 0", overlap_viol); end
  endtask

  task automatic test_gap_2x3();
    int bad;
    bit found;
    fill_random();
    m_x[1][1] = 16'hFE80;
    make_frame(2, 3, 1'b0);
    clear_obs();
    send_bytes(1, 1000);
    idle(2);
    bad = count_bad();
    checks++;
    if (bad !== 0 || obs_q.size() != 11) begin
      errors++; $display("FAIL gap_writes bad=%0d obs=%0d required 0 of 11", bad, obs_q.size());
    end
    found = 1'b0;
    foreach (obs_q[i])
      if (obs_q[i].kind == 2'd0 && obs_q[i].dp == 2'd1 && obs_q[i].feat == 2'd1 && obs_q[i].data == 16'hFE80)
        found = 1'b1;
    checks++;
    if (!found) begin errors++; $display("FAIL gap_neg_word found=%b required 1 (FE80 at dp1 f1)", found); end
    checks++;
    if (done_q.size() != 1 || err_q.size() != 0) begin
      errors++; $display("FAIL gap_done done=%0d err=%0d required 1/0", done_q.size(), err_q.size());
    end
    m_num_dps = 2; m_num_f = 3;
    checks++;
    if (int'(o_num_dps) != m_num_dps || int'(o_num_features) != m_num_f) begin
      errors++; $display("FAIL gap_num got %0d/%0d required 2/3", o_num_dps, o_num_features);
    end
  endtask

  task automatic test_bad_csum();
    int bad;
    set_default();
    make_frame(4, 4, 1'b1);
    clear_obs();
    send_bytes(0, 1000);
    checks++;
    if (o_load_err !== 1'b1 || o_load_done !== 1'b0) begin
      errors++; $display("FAIL csum_pulse err/done=%b%b required 10", o_load_err, o_load_done);
    end
    idle(2);
    bad = count_bad();
    checks++;
    if (bad !== 0 || obs_q.size() != 24) begin errors++; $display("FAIL csum_writes bad=%0d obs=%0d required 0 of 24", bad, obs_q.size()); end
    checks++;
    if (err_q.size() != 1 || done_q.size() != 0 || err_q[0] != xfer_q[xfer_q.size()-1]) begin
      errors++; $display("FAIL csum_err err=%0d done=%0d required 1/0", err_q.size(), done_q.size());
    end
    checks++;
    if (int'(o_num_dps) != m_num_dps || int'(o_num_features) != m_num_f) begin
      errors++; $display("FAIL csum_num got %0d/%0d required %0d/%0d", o_num_dps, o_num_features, m_num_dps, m_num_f);
    end
  endtask

  task automatic test_garbage_dim();
    int bad;
    logic [7:0] pre[$];
    pre = '{8'h00, 8'h5A, 8'hFF, 8'hA5, 8'h50};
    fill_random();
    make_frame(3, 2, 1'b0);
    frame_q = {pre, frame_q};
    clear_obs();
    send_bytes(0, 1000);
    idle(2);
    checks++;
    if (err_q.size() != 1 || err_q[0] != xfer_q[4]) begin
      errors++; $display("FAIL dim_err count=%0d at=%0d required 1 at %0d", err_q.size(),
                         err_q.size() > 0 ? err_q[0] : -1, xfer_q[4]);
    end
    checks++;
    if (xfer_q[5] - xfer_q[4] != 2) begin
      errors++; $display("FAIL dim_next_hdr gap=%0d required 2", xfer_q[5] - xfer_q[4]);
    end
    bad = count_bad();
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL dim_writes bad=%0d obs=%0d required 0 of %0d", bad, obs_q.size(), exp_q.size()); end
    m_num_dps = 3; m_num_f = 2;
    checks++;
    if (done_q.size() != 1 || int'(o_num_dps) != m_num_dps || int'(o_num_features) != m_num_f) begin
      errors++; $display("FAIL dim_recover done=%0d num=%0d/%0d required 1 3/2", done_q.size(), o_num_dps, o_num_features);
    end
  endtask

  task automatic test_rst_mid();
    int bad;
    set_default();
    make_frame(4, 4, 1'b0);
    clear_obs();
    send_bytes(0, 20);
    #2 i_rst = 1'b1;
    #1;
    m_num_dps = 4; m_num_f = 4;
    checks++;
    if (o_in_ready !== 1'b0 || {o_feat_we, o_y_we, o_wt_we, o_load_done, o_load_err, o_busy} !== 6'b0) begin
      errors++; $display("FAIL rstmid_flags ready=%b flags=%b required 0/000000", o_in_ready,
                         {o_feat_we, o_y_we, o_wt_we, o_load_done, o_load_err, o_busy});
    end
    checks++;
    if ({o_wr_dp, o_wr_feat, o_wr_data} !== 20'h0 || int'(o_num_dps) != m_num_dps || int'(o_num_features) != m_num_f) begin
      errors++; $display("FAIL rstmid_values wr=%h num=%0d/%0d required 0 4/4",
                         {o_wr_dp, o_wr_feat, o_wr_data}, o_num_dps, o_num_features);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    idle(3);
    checks++;
    if (done_q.size() != 0 || err_q.size() != 0) begin
      errors++; $display("FAIL rstmid_abort done=%0d err=%0d required 0/0", done_q.size(), err_q.size());
    end
    fill_random();
    make_frame(4, 4, 1'b0);
    clear_obs();
    send_bytes(2, 1000);
    idle(2);
    bad = count_bad();
    checks++;
    if (bad !== 0 || done_q.size() != 1 || err_q.size() != 0) begin
      errors++; $display("FAIL rstmid_next bad=%0d done=%0d err=%0d required 0/1/0", bad, done_q.size(), err_q.size());
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int ndp, nf, bad;
      bit corrupt;
      ndp = int'($urandom_range(1, 4));
      nf  = int'($urandom_range(1, 4));
      corrupt = ($urandom_range(0, 2) == 0);
      fill_random();
      make_frame(ndp, nf, corrupt);
      clear_obs();
      send_bytes(int'($urandom_range(0, 2)), 1000);
      idle(2);
      bad = count_bad();
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL rnd%0d_writes bad=%0d obs=%0d required 0 of %0d", t, bad, obs_q.size(), exp_q.size()); end
      if (!corrupt) begin m_num_dps = ndp; m_num_f = nf; end
      checks++;
      if (done_q.size() != (corrupt ? 0 : 1) || err_q.size() != (corrupt ? 1 : 0) ||
          int'(o_num_dps) != m_num_dps || int'(o_num_features) != m_num_f) begin
        errors++; $display("FAIL rnd%0d_outcome done=%0d err=%0d num=%0d/%0d required %0d/%0d %0d/%0d",
                           t, done_q.size(), err_q.size(), o_num_dps, o_num_features,
                           corrupt ? 0 : 1, corrupt ? 1 : 0, m_num_dps, m_num_f);
      end
      checks++;
      if (overlap_viol !== 0) begin errors++; $display("FAIL rnd%0d_overlap got %0d required 0", t, overlap_viol); end
    end
  endtask

  initial begin
    test_reset();
    test_good_4x4();
    test_gap_2x3();
    test_bad_csum();
    test_garbage_dim();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t required completion", $time);
    $fatal(1);
  end

endmodule
